// File: rtl/td4_pkg.sv
// Shared types and constants for the TD4 program loader.
package td4_pkg;

    localparam int         TD4_ROM_DEPTH = 16;
    localparam int         TD4_ROM_AW    = 4;
    localparam logic [7:0] TD4_HDR_BYTE  = 8'hA5;
    localparam logic [7:0] TD4_FILL_OP   = 8'h00;
    localparam int         TD4_TIMEOUT   = 255;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        START,
        RUN,
        ERR
    } loader_state_t;

    // Running checksum is a plain modulo-256 byte sum.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/td4_prog_loader_if.sv
// Byte-wide valid/ready stream carrying the program image into the loader.
interface td4_prog_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/td4_prog_mem.sv
// 16x8 program store: one synchronous write port, one combinational read
// port that returns the fill opcode beyond the committed program length.
module td4_prog_mem
    import td4_pkg::*;
(
    input  logic                  clock,
    input  logic                  we,
    input  logic [TD4_ROM_AW-1:0] waddr,
    input  logic [7:0]            wdata,
    input  logic [TD4_ROM_AW-1:0] raddr,
    input  logic [TD4_ROM_AW:0]   prog_len,
    output logic [7:0]            rdata
);

    logic [7:0] mem [TD4_ROM_DEPTH];

    // Write port; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = ({1'b0, raddr} < prog_len) ? mem[raddr] : TD4_FILL_OP;

endmodule

// File: rtl/td4_prog_loader.sv
// Frame receiver for the TD4 program memory. Holds the core in reset until
// a complete frame with a matching checksum has been committed.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset, hunting for the header byte
// LEN   | header seen, waiting for the length byte
// DATA  | writing program bytes, accumulating checksum
// CSUM  | waiting for the checksum byte
// START | one clean reset cycle for the core, input stalled
// RUN   | program committed, core released, header triggers reload
// ERR   | last frame aborted, hunting for the header byte
module td4_prog_loader
    import td4_pkg::*;
#(
    parameter int         DEPTH    = TD4_ROM_DEPTH,
    parameter logic [7:0] HDR_BYTE = TD4_HDR_BYTE,
    parameter int         TIMEOUT  = TD4_TIMEOUT
)
(
    input  logic                  clock,
    input  logic                  reset,
    td4_prog_loader_if.slave      in_bus,
    input  logic [TD4_ROM_AW-1:0] fetch_addr,
    output logic [7:0]            fetch_data,
    output logic                  cpu_reset_n,
    output logic                  loaded,
    output logic                  error,
    output logic                  busy
);

    localparam int         PLW     = TD4_ROM_AW + 1;
    localparam logic [7:0] MAX_LEN = 8'(DEPTH);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    loader_state_t         state;
    logic [PLW-1:0]        prog_len;
    logic [TD4_ROM_AW-1:0] wr_ptr;
    logic [7:0]            csum;
    logic [7:0]            timer;

    logic xfer;
    logic last_data;
    logic mem_we;

    assign in_bus.in_ready = (state != START);
    assign xfer            = in_bus.in_valid & in_bus.in_ready;
    assign last_data       = ({1'b0, wr_ptr} == (prog_len - 1'b1));
    assign mem_we          = (state == DATA) && xfer;

    td4_prog_mem u_mem (
        .clock    (clock),
        .we       (mem_we),
        .waddr    (wr_ptr),
        .wdata    (in_bus.in_data),
        .raddr    (fetch_addr),
        .prog_len (prog_len),
        .rdata    (fetch_data)
    );

    // Frame FSM with checksum, idle timer and registered status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            prog_len    <= '0;
            wr_ptr      <= '0;
            csum        <= '0;
            timer       <= '0;
            cpu_reset_n <= 1'b0;
            loaded      <= 1'b0;
            error       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE, RUN, ERR: begin
                    timer <= '0;
                    if (xfer && (in_bus.in_data == HDR_BYTE)) begin
                        state       <= LEN;
                        busy        <= 1'b1;
                        loaded      <= 1'b0;
                        error       <= 1'b0;
                        cpu_reset_n <= 1'b0;
                    end
                end
                LEN, DATA, CSUM: begin
                    if (xfer) begin
                        timer <= '0;
                        case (state)
                            LEN: begin
                                if ((in_bus.in_data == 8'h00) || (in_bus.in_data > MAX_LEN)) begin
                                    state  <= ERR;
                                    error  <= 1'b1;
                                    loaded <= 1'b0;
                                    busy   <= 1'b0;
                                end else begin
                                    prog_len <= in_bus.in_data[PLW-1:0];
                                    wr_ptr   <= '0;
                                    csum     <= '0;
                                    state    <= DATA;
                                end
                            end
                            DATA: begin
                                wr_ptr <= wr_ptr + 1'b1;
                                csum   <= csum_add(csum, in_bus.in_data);
                                if (last_data) begin
                                    state <= CSUM;
                                end
                            end
                            CSUM: begin
                                if (in_bus.in_data == csum) begin
                                    state <= START;
                                end else begin
                                    state  <= ERR;
                                    error  <= 1'b1;
                                    loaded <= 1'b0;
                                    busy   <= 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end else if (timer == TO_LAST) begin
                        // A transfer on this edge would have won; none came.
                        timer  <= '0;
                        state  <= ERR;
                        error  <= 1'b1;
                        loaded <= 1'b0;
                        busy   <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                START: begin
                    state       <= RUN;
                    busy        <= 1'b0;
                    loaded      <= 1'b1;
                    cpu_reset_n <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_td4_prog_loader.sv
// Bench for td4_prog_loader: directed vector table, hand-written corner
// sequences, then randomized frames against a frame-level reference model.
module tb_td4_prog_loader;
    import td4_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] fetch_addr = 4'd0;
    logic [7:0] fetch_data;
    logic       cpu_reset_n, loaded, error, busy;

    td4_prog_loader_if bus ();

    td4_prog_loader dut (
        .clock       (clock),
        .reset       (reset),
        .in_bus      (bus),
        .fetch_addr  (fetch_addr),
        .fetch_data  (fetch_data),
        .cpu_reset_n (cpu_reset_n),
        .loaded      (loaded),
        .error       (error),
        .busy        (busy)
    );

    always #50 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model (frame level) ----------------
    bit         m_in_frame, m_start_pend, m_loaded, m_error;
    logic [7:0] m_fr [$];
    int         m_len, m_idle;
    logic [7:0] m_mem [16];

    task automatic model_reset();
        m_in_frame = 0; m_start_pend = 0; m_loaded = 0; m_error = 0;
        m_len = 0; m_idle = 0; m_fr.delete();
    endtask

    task automatic model_abort();
        m_in_frame = 0; m_error = 1; m_loaded = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int L, s;
        m_idle = 0;
        if (!m_in_frame) begin
            if (b == 8'hA5) begin
                m_in_frame = 1; m_fr.delete(); m_loaded = 0; m_error = 0;
            end
        end else begin
            m_fr.push_back(b);
            L = int'(m_fr[0]);
            if (m_fr.size() == 1) begin
                if (L == 0 || L > 16) model_abort();
                else m_len = L;
            end else if (m_fr.size() <= L + 1) begin
                m_mem[m_fr.size() - 2] = b;
            end else begin
                s = 0;
                for (int i = 1; i <= L; i++) s += int'(m_fr[i]);
                if ((s % 256) == int'(b)) begin
                    m_in_frame = 0; m_start_pend = 1;
                end else model_abort();
            end
        end
    endtask

    task automatic model_idle();
        if (m_start_pend) begin
            m_start_pend = 0; m_loaded = 1;
        end else if (m_in_frame) begin
            m_idle++;
            if (m_idle == 255) model_abort();
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic chk_fetch(input string name, input int addr, input logic [7:0] exp);
        fetch_addr = 4'(addr);
        #1;
        chk($sformatf("%s_fetch%0d", name, addr), 32'(fetch_data), 32'(exp));
    endtask

    task automatic check_all(input string name);
        logic [7:0] e;
        chk({name, "_busy"},  32'(busy),        32'(m_in_frame | m_start_pend));
        chk({name, "_error"}, 32'(error),       32'(m_error));
        chk({name, "_loaded"},32'(loaded),      32'(m_loaded));
        chk({name, "_rstn"},  32'(cpu_reset_n), 32'(m_loaded));
        chk({name, "_ready"}, 32'(bus.in_ready),32'(!m_start_pend));
        for (int a = 0; a < 16; a++) begin
            e = (a < m_len) ? m_mem[a] : 8'h00;
            chk_fetch(name, a, e);
        end
    endtask

    // ---------------- stimulus helpers (start and end on a negedge) ----------------
    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clock);
            model_idle();
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && n < 4) begin
            @(negedge clock);
            model_idle();
            n++;
        end
        if (!bus.in_ready) begin
            errors++;
            $display("FAIL send_ready_timeout act=0 exp=1");
        end
        @(negedge clock);
        model_byte(b);
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(negedge clock);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        model_reset();
    endtask

    task automatic chk_flags(input string name, input bit bu, input bit er, input bit ld, input bit rn);
        chk({name, "_busy"},   32'(busy),        32'(bu));
        chk({name, "_error"},  32'(error),       32'(er));
        chk({name, "_loaded"}, 32'(loaded),      32'(ld));
        chk({name, "_rstn"},   32'(cpu_reset_n), 32'(rn));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         send;
        logic [7:0] b;
        int         idle;
        bit         busy, err, ld, rn;
    } vec_t;

    vec_t vecs [$];

    function automatic void addv(input bit s, input logic [7:0] b, input int idle,
                                 input bit bu, input bit er, input bit ld, input bit rn);
        vec_t v;
        v.send = s; v.b = b; v.idle = idle;
        v.busy = bu; v.err = er; v.ld = ld; v.rn = rn;
        vecs.push_back(v);
    endfunction

    task automatic apply_range(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            if (vecs[i].send) send(vecs[i].b);
            idle_cycles(vecs[i].idle);
            chk_flags($sformatf("vec%0d", i), vecs[i].busy, vecs[i].err, vecs[i].ld, vecs[i].rn);
        end
    endtask

    // ---------------- random frame generator ----------------
    task automatic rand_gap();
        idle_cycles($urandom_range(0, 2));
    endtask

    task automatic good_frame(input int len);
        logic [7:0] d;
        int s;
        s = 0;
        send(8'hA5); rand_gap();
        send(8'(len)); rand_gap();
        for (int i = 0; i < len; i++) begin
            d = 8'($urandom);
            s += int'(d);
            send(d); rand_gap();
        end
        send(8'(s));
    endtask

    task automatic bad_csum_frame(input int len);
        logic [7:0] d;
        int s;
        s = 0;
        send(8'hA5);
        send(8'(len));
        for (int i = 0; i < len; i++) begin
            d = 8'($urandom);
            s += int'(d);
            send(d); rand_gap();
        end
        send(8'(s + 1 + int'($urandom_range(0, 254))));
    endtask

    int n1, n2, n3, kind, len;
    logic [7:0] nb;

    initial begin
        #5_000_000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // test 1: nominal load
        addv(1, 8'hA5, 0, 1, 0, 0, 0);
        addv(1, 8'h03, 0, 1, 0, 0, 0);
        addv(1, 8'h31, 0, 1, 0, 0, 0);
        addv(1, 8'h42, 0, 1, 0, 0, 0);
        addv(1, 8'hF0, 0, 1, 0, 0, 0);
        addv(1, 8'h63, 0, 1, 0, 0, 0);
        addv(0, 8'h00, 1, 0, 0, 1, 1);
        n1 = vecs.size();
        // test 2: bad checksum then recovery
        addv(1, 8'hA5, 0, 1, 0, 0, 0);
        addv(1, 8'h02, 0, 1, 0, 0, 0);
        addv(1, 8'h10, 0, 1, 0, 0, 0);
        addv(1, 8'h20, 0, 1, 0, 0, 0);
        addv(1, 8'h31, 0, 0, 1, 0, 0);
        addv(1, 8'hA5, 0, 1, 0, 0, 0);
        addv(1, 8'h01, 0, 1, 0, 0, 0);
        addv(1, 8'hB7, 0, 1, 0, 0, 0);
        addv(1, 8'hB7, 0, 1, 0, 0, 0);
        addv(0, 8'h00, 1, 0, 0, 1, 1);
        n2 = vecs.size();
        // test 3: length bounds
        addv(1, 8'hA5, 0, 1, 0, 0, 0);
        addv(1, 8'h00, 0, 0, 1, 0, 0);
        addv(1, 8'hA5, 0, 1, 0, 0, 0);
        addv(1, 8'h11, 0, 0, 1, 0, 0);
        addv(1, 8'hA5, 0, 1, 0, 0, 0);
        addv(1, 8'h10, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 16; i++) addv(1, 8'(i), 0, 1, 0, 0, 0);
        addv(1, 8'h88, 0, 1, 0, 0, 0);
        addv(0, 8'h00, 1, 0, 0, 1, 1);
        n3 = vecs.size();

        // reset state
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_reset();
        chk_flags("reset", 0, 0, 0, 0);
        chk("reset_ready", 32'(bus.in_ready), 32'd1);
        chk_fetch("reset", 0, 8'h00);

        apply_range(0, n1);
        chk_fetch("t1", 0, 8'h31);
        chk_fetch("t1", 1, 8'h42);
        chk_fetch("t1", 2, 8'hF0);
        chk_fetch("t1", 3, 8'h00);
        chk_fetch("t1", 15, 8'h00);

        apply_range(n1, n2);
        chk_fetch("t2", 0, 8'hB7);
        chk_fetch("t2", 1, 8'h00);

        apply_range(n2, n3);
        chk_fetch("t3", 0, 8'h01);
        chk_fetch("t3", 15, 8'h10);

        // test 4: timeout boundary; transfer on the would-expire edge wins
        send(8'hA5); send(8'h04); send(8'h01);
        idle_cycles(254);
        chk_flags("to_254a", 1, 0, 0, 0);
        send(8'h02);
        chk_flags("to_save", 1, 0, 0, 0);
        idle_cycles(254);
        chk_flags("to_254b", 1, 0, 0, 0);
        idle_cycles(1);
        chk_flags("to_255", 0, 1, 0, 0);

        // test 5: reload from RUN, then reset mid-frame
        send(8'hA5); send(8'h01); send(8'hB7); send(8'hB7);
        idle_cycles(1);
        chk_flags("t5_run", 0, 0, 1, 1);
        send(8'hA5);
        chk_flags("t5_reload", 1, 0, 0, 0);
        send(8'h02); send(8'h11);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h33;
        do_reset(1);
        chk_flags("t5_midrst", 0, 0, 0, 0);
        chk("t5_midrst_ready", 32'(bus.in_ready), 32'd1);
        for (int a = 0; a < 16; a++) chk_fetch("t5_midrst", a, 8'h00);

        // test 6: noise in IDLE, backpressure in START
        send(8'h00); chk_flags("t6_n00", 0, 0, 0, 0);
        send(8'hFF); chk_flags("t6_nff", 0, 0, 0, 0);
        send(8'h12); chk_flags("t6_n12", 0, 0, 0, 0);
        send(8'hA5); send(8'h01); send(8'h5A); send(8'h5A);
        chk_flags("t6_start", 1, 0, 0, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        chk("t6_ready_start", 32'(bus.in_ready), 32'd0);
        @(negedge clock);
        model_idle();
        chk("t6_ready_run", 32'(bus.in_ready), 32'd1);
        chk_flags("t6_run_held", 0, 0, 1, 1);
        @(negedge clock);
        model_byte(8'hA5);
        bus.in_valid = 1'b0;
        chk_flags("t6_accepted", 1, 0, 0, 0);

        // randomized frames against the reference model
        do_reset(2);
        good_frame(16);
        check_all("rinit_start");
        idle_cycles(1);
        check_all("rinit_run");
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 5);
            len  = $urandom_range(1, 16);
            case (kind)
                0, 1: begin
                    good_frame(len);
                    check_all($sformatf("r%0d_good_start", it));
                    idle_cycles(1);
                end
                2: bad_csum_frame(len);
                3: begin
                    send(8'hA5);
                    if ($urandom_range(0, 1) == 0) send(8'h00);
                    else send(8'($urandom_range(17, 255)));
                end
                4: begin
                    repeat ($urandom_range(1, 3)) begin
                        nb = 8'($urandom);
                        if (nb == 8'hA5) nb = 8'h5A;
                        send(nb);
                    end
                end
                default: begin
                    send(8'hA5);
                    send(8'(len));
                    repeat ($urandom_range(0, len - 1)) send(8'($urandom));
                    idle_cycles(255);
                end
            endcase
            check_all($sformatf("r%0d_k%0d", it, kind));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
